// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle between the convolution stage and the 2x2 max pooler.
//   in_valid    : upstream pixel strobe
//   inputPixel  : raster-order input pixel
//   outputPixel : pooled pixel (registered in the pooler)
//   out_valid   : pooled pixel strobe
//   frame_done  : pulse with the last pooled pixel of a frame
// master = upstream/downstream environment, slave = the pooler.
interface max_pool_2x2_if #(
    parameter int unsigned WORD_SIZE = 8
);
    logic                 in_valid;
    logic [WORD_SIZE-1:0] inputPixel;
    logic [WORD_SIZE-1:0] outputPixel;
    logic                 out_valid;
    logic                 frame_done;

    modport master (
        output in_valid,
        output inputPixel,
        input  outputPixel,
        input  out_valid,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  inputPixel,
        output outputPixel,
        output out_valid,
        output frame_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Non-overlapping 2x2 max pooling, stride 2, on a raster-order pixel stream.
// Even-column pixels are parked in a pair register; odd-column pixels form the
// horizontal max. Even rows park that max in a half-row line buffer, odd rows
// combine it with the buffered value and emit one pooled pixel a cycle later.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   pool : max_pool_2x2_if slave port (in_valid/inputPixel in,
//          outputPixel/out_valid/frame_done out, all outputs registered)
// The interface WORD_SIZE must match this module's WORD_SIZE.
module max_pool_2x2 #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ROW_SIZE  = 540,
    parameter int unsigned NUM_ROWS  = 540
) (
    input  logic           clk,
    input  logic           rst,
    max_pool_2x2_if.slave  pool
);
    localparam int unsigned HALF_ROW = ROW_SIZE / 2;
    localparam int unsigned COL_W    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned IDX_W    = (HALF_ROW > 1) ? $clog2(HALF_ROW) : 1;

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;

    // Data path storage; every entry is rewritten before it is read, so no reset.
    logic [WORD_SIZE-1:0] pair_q;
    logic [WORD_SIZE-1:0] line_buf [HALF_ROW];

    // Registered outputs.
    logic [WORD_SIZE-1:0] out_pixel_q;
    logic                 out_valid_q;
    logic                 frame_done_q;

    // Combinational helpers.
    logic                 col_odd_c;
    logic                 row_odd_c;
    logic                 col_last_c;
    logic                 row_last_c;
    logic [IDX_W-1:0]     lb_idx_c;
    logic [WORD_SIZE-1:0] lb_rd_c;
    logic [WORD_SIZE-1:0] hmax_c;
    logic [WORD_SIZE-1:0] vmax_c;
    logic                 emit_c;

    // Position decode and max trees.
    always_comb begin
        col_odd_c  = col_q[0];
        row_odd_c  = row_q[0];
        col_last_c = (col_q == COL_W'(ROW_SIZE - 1));
        row_last_c = (row_q == ROW_W'(NUM_ROWS - 1));
        lb_idx_c   = IDX_W'(col_q >> 1);
        lb_rd_c    = line_buf[lb_idx_c];
        hmax_c     = (pair_q > pool.inputPixel) ? pair_q : pool.inputPixel;
        vmax_c     = (lb_rd_c > hmax_c) ? lb_rd_c : hmax_c;
        // Bottom-right pixel of a 2x2 block is being accepted.
        emit_c     = pool.in_valid && col_odd_c && row_odd_c;
    end

    // Column/row counters; advance only on accepted pixels, wrap per row/frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pool.in_valid) begin
            if (col_last_c) begin
                col_q <= '0;
                row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Pair register and line buffer writes.
    always_ff @(posedge clk) begin
        if (pool.in_valid && !col_odd_c) begin
            pair_q <= pool.inputPixel;
        end
        if (pool.in_valid && col_odd_c && !row_odd_c) begin
            line_buf[lb_idx_c] <= hmax_c;
        end
    end

    // Output stage: one-cycle strobe, pixel held between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pixel_q  <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= emit_c;
            frame_done_q <= emit_c && col_last_c && row_last_c;
            if (emit_c) begin
                out_pixel_q <= vmax_c;
            end
        end
    end

    assign pool.outputPixel = out_pixel_q;
    assign pool.out_valid   = out_valid_q;
    assign pool.frame_done  = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 (WORD_SIZE=8, ROW_SIZE=4, NUM_ROWS=4).
// The driver feeds a frame array reference model that pushes the expected
// pooled pixel, frame_done flag and arrival cycle; a negedge monitor checks.
module tb_max_pool_2x2;
    localparam int unsigned WS = 8;
    localparam int unsigned RS = 4;
    localparam int unsigned NR = 4;

    typedef struct {
        int pix;
        bit fd;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    max_pool_2x2_if #(.WORD_SIZE(WS)) bus ();

    max_pool_2x2 #(
        .WORD_SIZE (WS),
        .ROW_SIZE  (RS),
        .NUM_ROWS  (NR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pool (bus)
    );

    exp_t sb[$];
    int   cyc = 0;
    logic rst_seen;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_fd = 0;
    int   got_fd = 0;
    int   last_out = 0;
    int   m_row = 0;
    int   m_col = 0;
    int   frame [NR][RS];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: place the pixel in the frame; at a block's bottom-right
    // corner the expected output is the max of the four block pixels.
    task automatic model_accept(input int p);
        int m;
        bit fd;
        frame[m_row][m_col] = p;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            m = frame[m_row-1][m_col-1];
            if (frame[m_row-1][m_col] > m) m = frame[m_row-1][m_col];
            if (frame[m_row][m_col-1] > m) m = frame[m_row][m_col-1];
            if (frame[m_row][m_col]   > m) m = frame[m_row][m_col];
            fd = (m_row == NR - 1) && (m_col == RS - 1);
            if (fd) exp_fd++;
            sb.push_back('{m, fd, cyc + 1});
        end
        m_col++;
        if (m_col == RS) begin
            m_col = 0;
            m_row++;
            if (m_row == NR) m_row = 0;
        end
    endtask

    // idle cycles with in_valid low and junk on the data bus, then one pixel.
    task automatic drive(input int p, input int idle);
        repeat (idle) begin
            @(negedge clk);
            bus.in_valid   = 1'b0;
            bus.inputPixel = WS'($urandom);
        end
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.inputPixel = WS'(p);
        model_accept(p);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid   = 1'b0;
            bus.inputPixel = WS'($urandom);
        end
    endtask

    // Reset with random in_valid activity that must be ignored.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst            = 1'b1;
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.inputPixel = WS'($urandom);
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        m_row        = 0;
        m_col        = 0;
    endtask

    task automatic ramp_frame(input int base, input int gap);
        for (int i = 0; i < RS * NR; i++) drive(base + i, gap);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen === 1'b1) begin
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_frame_done", int'(bus.frame_done), 0);
            check("rst_output_pixel", int'(bus.outputPixel), 0);
            last_out = 0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("output_missing", 0, e.pix + 1000);
            end
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_pixel", int'(bus.outputPixel), e.pix);
                    check("frame_done", int'(bus.frame_done), int'(e.fd));
                end
                last_out = int'(bus.outputPixel);
                if (bus.frame_done === 1'b1) got_fd++;
            end else begin
                check("out_valid_low", int'(bus.out_valid), 0);
                check("hold_output_pixel", int'(bus.outputPixel), last_out);
                check("frame_done_idle", int'(bus.frame_done), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.inputPixel = '0;
        do_reset(3);

        // Continuous ramp 0..15: outputs 5, 7, 13, 15.
        ramp_frame(0, 0);
        idle_cycles(2);

        // Same ramp with in_valid low on alternate cycles.
        ramp_frame(0, 1);
        idle_cycles(2);

        // Sparse frame: (0,1)=200, (3,2)=255 -> 200, 0, 0, 255.
        for (int i = 0; i < RS * NR; i++) begin
            p = (i == 1) ? 200 : ((i == 14) ? 255 : 0);
            drive(p, 0);
        end
        // All-255 frame: ties everywhere.
        for (int i = 0; i < RS * NR; i++) drive(255, 0);
        idle_cycles(2);

        // Mid-frame reset after 6 pixels, then a full ramp frame.
        for (int i = 0; i < 6; i++) drive(i, 0);
        do_reset(2);
        ramp_frame(0, 0);
        idle_cycles(2);

        // Back-to-back frames: ramp then ramp+16.
        ramp_frame(0, 0);
        ramp_frame(16, 0);
        idle_cycles(2);

        // Random frames with random gaps (pair splits, row boundaries).
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < RS * NR; i++) begin
                drive($urandom_range(0, 255),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
        end

        // Random partial frame, reset, then a random frame.
        for (int i = 0; i < $urandom_range(1, 14); i++) drive($urandom_range(0, 255), 0);
        do_reset(2);
        for (int i = 0; i < RS * NR; i++) drive($urandom_range(0, 255), $urandom_range(0, 1));

        idle_cycles(5);
        check("scoreboard_drained", sb.size(), 0);
        check("frame_done_count", got_fd, exp_fd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
